// File: rtl/median_window_ctrl.sv
// ---------------------------------------------------------------------------
// median_window_ctrl
//   Streaming 3x3 median filter controller. Accepts raster-order pixels over
//   a valid/ready stream, keeps two line buffers plus a 3-column window and
//   emits one registered median per interior pixel.
//
//   Optional feature macro: MEDIAN_SOF_RESYNC_EN
//     defined   : s_sof seen mid-frame restarts the frame and sets sticky err
//     undefined : s_sof is ignored outside IDLE, err tied 0
//
// Ports
//   clk, rst           single clock, asynchronous active-high reset
//   s_valid/s_ready    input pixel handshake
//   s_data, s_sof      input pixel and first-pixel-of-frame marker
//   m_valid/m_ready    median output handshake
//   m_data, m_eof      median value and last-median-of-frame marker
//   busy               frame in progress
//   err                sticky mid-frame SOF flag (resync build only)
//
// Also contains pixel_network: combinational 3x3 median of nine pixels.
// ---------------------------------------------------------------------------

module pixel_network #(
    parameter int DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0] c1h,
    input  logic [DATA_WIDTH-1:0] c1m,
    input  logic [DATA_WIDTH-1:0] c1l,
    input  logic [DATA_WIDTH-1:0] c2h,
    input  logic [DATA_WIDTH-1:0] c2m,
    input  logic [DATA_WIDTH-1:0] c2l,
    input  logic [DATA_WIDTH-1:0] c3h,
    input  logic [DATA_WIDTH-1:0] c3m,
    input  logic [DATA_WIDTH-1:0] c3l,
    output logic [DATA_WIDTH-1:0] med
);
    typedef logic [DATA_WIDTH-1:0] pix_t;

    function automatic pix_t mn(input pix_t a, input pix_t b);
        return (a < b) ? a : b;
    endfunction

    function automatic pix_t mx(input pix_t a, input pix_t b);
        return (a < b) ? b : a;
    endfunction

    function automatic pix_t md3(input pix_t a, input pix_t b, input pix_t c);
        return mx(mn(a, b), mn(mx(a, b), c));
    endfunction

    pix_t lo1, lo2, lo3, mi1, mi2, mi3, hi1, hi2, hi3;

    // Per-column sort, then median of (max of lows, median of mids, min of highs).
    assign lo1 = mn(mn(c1h, c1m), c1l);
    assign lo2 = mn(mn(c2h, c2m), c2l);
    assign lo3 = mn(mn(c3h, c3m), c3l);
    assign mi1 = md3(c1h, c1m, c1l);
    assign mi2 = md3(c2h, c2m, c2l);
    assign mi3 = md3(c3h, c3m, c3l);
    assign hi1 = mx(mx(c1h, c1m), c1l);
    assign hi2 = mx(mx(c2h, c2m), c2l);
    assign hi3 = mx(mx(c3h, c3m), c3l);

    assign med = md3(mx(mx(lo1, lo2), lo3), md3(mi1, mi2, mi3), mn(mn(hi1, hi2), hi3));
endmodule

module median_window_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_sof,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_eof,
    output logic                  busy,
    output logic                  err
);
    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_PRIME = 2'd1;
    localparam logic [1:0] ST_RUN   = 2'd2;

    logic [1:0]            state;
    logic [CW-1:0]         col;
    logic [RW-1:0]         row;
    logic [DATA_WIDTH-1:0] lb0 [IMG_WIDTH];
    logic [DATA_WIDTH-1:0] lb1 [IMG_WIDTH];
    logic [DATA_WIDTH-1:0] c1h, c1m, c1l, c2h, c2m, c2l, c3h, c3m, c3l;
    logic                  win_valid, win_eof;

    logic                  adv, accept, restart, pix_acc;
    logic [CW-1:0]         px_col;
    logic [RW-1:0]         px_row;
    logic                  px_row_end, px_last, px_in_win;
    logic [DATA_WIDTH-1:0] top, mid, med;

    assign adv     = !m_valid || m_ready;
    assign s_ready = adv;
    assign accept  = s_valid && s_ready;
    assign busy    = (state != ST_IDLE);

`ifdef MEDIAN_SOF_RESYNC_EN
    assign restart = accept && s_sof;
`else
    assign restart = accept && s_sof && (state == ST_IDLE);
`endif

    // Beats in IDLE without SOF are discarded and touch nothing.
    assign pix_acc = accept && ((state != ST_IDLE) || s_sof);

    // Position of the pixel being accepted; an SOF pixel is always (0,0).
    assign px_col     = restart ? '0 : col;
    assign px_row     = restart ? '0 : row;
    assign px_row_end = (px_col == COL_LAST);
    assign px_last    = px_row_end && (px_row == ROW_LAST);
    assign px_in_win  = (px_row >= RW'(2)) && (px_col >= CW'(2));

    assign top = lb1[px_col];
    assign mid = lb0[px_col];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            col   <= '0;
            row   <= '0;
        end else if (pix_acc) begin
            if (restart) begin
                state <= ST_PRIME;
                col   <= CW'(1);
                row   <= '0;
            end else if (px_last) begin
                state <= ST_IDLE;
                col   <= '0;
                row   <= '0;
            end else if (px_row_end) begin
                col <= '0;
                row <= row + RW'(1);
                if (row == RW'(1)) state <= ST_RUN;
            end else begin
                col <= col + CW'(1);
            end
        end
    end

`ifdef MEDIAN_SOF_RESYNC_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                               err <= 1'b0;
        else if (restart && state != ST_IDLE)  err <= 1'b1;
    end
`else
    assign err = 1'b0;
`endif

    // Line buffers are not reset: rows 0 and 1 overwrite them before any
    // window built from them is marked valid.
    always_ff @(posedge clk) begin
        if (pix_acc) begin
            lb1[px_col] <= lb0[px_col];
            lb0[px_col] <= s_data;
        end
    end

    pixel_network #(.DATA_WIDTH(DATA_WIDTH)) u_net (
        .c1h(c1h), .c1m(c1m), .c1l(c1l),
        .c2h(c2h), .c2m(c2m), .c2l(c2l),
        .c3h(c3h), .c3m(c3m), .c3l(c3l),
        .med(med)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            {c1h, c1m, c1l} <= '0;
            {c2h, c2m, c2l} <= '0;
            {c3h, c3m, c3l} <= '0;
            win_valid       <= 1'b0;
            win_eof         <= 1'b0;
            m_valid         <= 1'b0;
            m_data          <= '0;
            m_eof           <= 1'b0;
        end else begin
            if (pix_acc) begin
                {c3h, c3m, c3l} <= {c2h, c2m, c2l};
                {c2h, c2m, c2l} <= {c1h, c1m, c1l};
                {c1h, c1m, c1l} <= {top, mid, s_data};
            end
            // Both stages move together so a stalled sink freezes the window.
            if (adv) begin
                win_valid <= pix_acc && px_in_win;
                win_eof   <= pix_acc && px_last;
                m_valid   <= win_valid;
                m_data    <= med;
                m_eof     <= win_eof;
            end
        end
    end
endmodule

// File: tb/tb_median_window_ctrl.sv
module tb_median_window_ctrl;
    localparam int DW = 8;
`ifdef MEDIAN_SOF_RESYNC_EN
    localparam int RESYNC = 1;
`else
    localparam int RESYNC = 0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // unit 0: 3x3 image, unit 1: 4x4 image
    logic          s_valid3, s_sof3, s_ready3, m_valid3, m_eof3, busy3, err3;
    logic          m_ready3;
    logic [DW-1:0] s_data3, m_data3;
    logic          s_valid4, s_sof4, s_ready4, m_valid4, m_eof4, busy4, err4;
    logic          m_ready4 = 1'b1;
    logic [DW-1:0] s_data4, m_data4;

    median_window_ctrl #(.DATA_WIDTH(DW), .IMG_WIDTH(3), .IMG_HEIGHT(3)) u_dut3 (
        .clk(clk), .rst(rst),
        .s_valid(s_valid3), .s_ready(s_ready3), .s_data(s_data3), .s_sof(s_sof3),
        .m_valid(m_valid3), .m_ready(m_ready3), .m_data(m_data3), .m_eof(m_eof3),
        .busy(busy3), .err(err3)
    );

    median_window_ctrl #(.DATA_WIDTH(DW), .IMG_WIDTH(4), .IMG_HEIGHT(4)) u_dut4 (
        .clk(clk), .rst(rst),
        .s_valid(s_valid4), .s_ready(s_ready4), .s_data(s_data4), .s_sof(s_sof4),
        .m_valid(m_valid4), .m_ready(m_ready4), .m_data(m_data4), .m_eof(m_eof4),
        .busy(busy4), .err(err4)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Sink backpressure for unit 1: 0 = always ready, 1 = 1-0-0-1 pattern, 2 = random
    int         bp_mode = 0;
    int         bp_i    = 0;
    logic [3:0] bp_pat  = 4'b1001;
    always @(posedge clk) begin
        #1;
        if (bp_mode == 1) begin
            m_ready4 = bp_pat[bp_i % 4];
            bp_i     = bp_i + 1;
        end else if (bp_mode == 2) begin
            m_ready4 = 1'($urandom_range(0, 1));
        end else begin
            m_ready4 = 1'b1;
        end
    end

    // Reference model: image array, expected medians as {eof, data}
    int img[16];
    int exp_q3[$];
    int exp_q4[$];
    int out_cyc4[$];
    int last_acc[2];
    int last_out[2];
    logic          prev_stall[2];
    logic [DW-1:0] prev_data[2];
    logic          prev_eof[2];

    function automatic int qsize(input int u);
        return (u == 0) ? exp_q3.size() : exp_q4.size();
    endfunction

    function automatic int med_at(input int w, input int r, input int c);
        int q[$];
        for (int dr = -1; dr <= 1; dr++)
            for (int dc = -1; dc <= 1; dc++)
                q.push_back(img[(r + dr) * w + c + dc]);
        q.sort();
        return q[4];
    endfunction

    task automatic expect_frame(input int u, input int w, input int h);
        int e;
        for (int r = 1; r <= h - 2; r++)
            for (int c = 1; c <= w - 2; c++) begin
                e = med_at(w, r, c) | (((r == h - 2) && (c == w - 2)) ? 256 : 0);
                if (u == 0) exp_q3.push_back(e);
                else        exp_q4.push_back(e);
            end
    endtask

    task automatic mon(input int u, input logic mv, input logic mr, input logic sr,
                       input logic [DW-1:0] md, input logic me);
        int e;
        if (prev_stall[u]) begin
            check("hold_valid", mv, 1);
            check("hold_data", md, prev_data[u]);
            check("hold_eof", me, prev_eof[u]);
        end
        if (mv && !mr) check("s_ready_stall", sr, 0);
        prev_stall[u] = mv && !mr;
        prev_data[u]  = md;
        prev_eof[u]   = me;
        if (mv && mr) begin
            last_out[u] = cyc;
            if (u == 1) out_cyc4.push_back(cyc);
            if (qsize(u) == 0) begin
                check("unexpected_out", 1, 0);
            end else begin
                if (u == 0) e = exp_q3.pop_front();
                else        e = exp_q4.pop_front();
                check("m_data", md, e & 255);
                check("m_eof", me, e >> 8);
            end
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            prev_stall[0] = 1'b0;
            prev_stall[1] = 1'b0;
        end else begin
            mon(0, m_valid3, m_ready3, s_ready3, m_data3, m_eof3);
            mon(1, m_valid4, m_ready4, s_ready4, m_data4, m_eof4);
        end
    end

    task automatic send(input int u, input int d, input logic sof);
        int n = 0;
        if (u == 0) begin s_valid3 = 1'b1; s_data3 = DW'(d); s_sof3 = sof; end
        else        begin s_valid4 = 1'b1; s_data4 = DW'(d); s_sof4 = sof; end
        forever begin
            @(negedge clk);
            if ((u == 0) ? s_ready3 : s_ready4) break;
            n++;
            if (n > 200) begin check("accept_timeout", 0, 1); break; end
        end
        last_acc[u] = cyc;
        @(posedge clk); #1;
        if (u == 0) begin s_valid3 = 1'b0; s_sof3 = 1'b0; end
        else        begin s_valid4 = 1'b0; s_sof4 = 1'b0; end
    endtask

    task automatic send_img(input int u, input int w, input int h);
        for (int i = 0; i < w * h; i++) send(u, img[i], i == 0);
    endtask

    task automatic drain(input int u);
        int n = 0;
        while (qsize(u) != 0 && n < 200) begin @(negedge clk); n++; end
        check("drain", qsize(u), 0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int pre[4];
        rst = 1'b1;
        s_valid3 = 1'b0; s_sof3 = 1'b0; s_data3 = '0; m_ready3 = 1'b1;
        s_valid4 = 1'b0; s_sof4 = 1'b0; s_data4 = '0;
        prev_stall[0] = 1'b0; prev_stall[1] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_m_valid", m_valid3, 0);
        check("rst_m_data", m_data3, 0);
        check("rst_m_eof", m_eof3, 0);
        check("rst_busy", busy3, 0);
        check("rst_err", err3, 0);
        check("rst_s_ready", s_ready3, 1);
        check("rst_m_valid4", m_valid4, 0);
        check("rst_s_ready4", s_ready4, 1);
        rst = 1'b0;
        @(posedge clk); #1;

        // 3x3 frame 1..9: single median 5 with eof, two cycles after last accept
        for (int i = 0; i < 9; i++) img[i] = i + 1;
        expect_frame(0, 3, 3);
        send_img(0, 3, 3);
        drain(0);
        check("latency3", last_out[0] - last_acc[0], 2);
        check("busy_after3", busy3, 0);
        check("err_normal", err3, 0);

        // 4x4 ramp, sink always ready: 5,6,9,10 with no bubbles in a row
        for (int i = 0; i < 16; i++) img[i] = i;
        out_cyc4.delete();
        expect_frame(1, 4, 4);
        send_img(1, 4, 4);
        drain(1);
        check("n_out4", out_cyc4.size(), 4);
        if (out_cyc4.size() == 4) begin
            check("no_bubble_a", out_cyc4[1] - out_cyc4[0], 1);
            check("no_bubble_b", out_cyc4[3] - out_cyc4[2], 1);
        end

        // 4x4 ramp with 1-0-0-1 backpressure
        bp_mode = 1;
        expect_frame(1, 4, 4);
        send_img(1, 4, 4);
        drain(1);

        // Back-to-back random frames with random backpressure
        bp_mode = 2;
        for (int f = 0; f < 4; f++) begin
            for (int i = 0; i < 16; i++) img[i] = int'($urandom_range(0, 255));
            expect_frame(1, 4, 4);
            send_img(1, 4, 4);
        end
        drain(1);
        bp_mode = 0;
        check("busy_after4", busy4, 0);

        // IDLE discard: three beats without SOF, then frame 1..9
        for (int i = 0; i < 3; i++) send(0, int'($urandom_range(0, 255)), 1'b0);
        check("idle_busy", busy3, 0);
        for (int i = 0; i < 9; i++) img[i] = i + 1;
        expect_frame(0, 3, 3);
        send_img(0, 3, 3);
        drain(0);

        // Mid-frame SOF at (1,1) followed by a full frame 1..9
        for (int i = 0; i < 4; i++) pre[i] = int'($urandom_range(0, 255));
        if (RESYNC != 0) begin
            for (int i = 0; i < 9; i++) img[i] = i + 1;
        end else begin
            for (int i = 0; i < 4; i++) img[i] = pre[i];
            for (int i = 4; i < 9; i++) img[i] = i - 3;
        end
        expect_frame(0, 3, 3);
        for (int i = 0; i < 4; i++) send(0, pre[i], i == 0);
        for (int v = 1; v <= 9; v++) send(0, v, v == 1);
        drain(0);
        check("resync_err", err3, RESYNC);
        check("resync_busy", busy3, 0);

        // Reset during row 2
        for (int i = 0; i < 7; i++) send(0, int'($urandom_range(0, 255)), i == 0);
        check("midframe_busy", busy3, 1);
        rst = 1'b1;
        #1;
        check("mrst_m_valid", m_valid3, 0);
        check("mrst_busy", busy3, 0);
        check("mrst_s_ready", s_ready3, 1);
        check("mrst_err", err3, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < 9; i++) img[i] = i + 1;
        expect_frame(0, 3, 3);
        send_img(0, 3, 3);
        drain(0);

        check("final_q3", exp_q3.size(), 0);
        check("final_q4", exp_q4.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
